// File: rtl/push_pkg.sv
// Shared definitions for the push-button front end: FSM states, channel indices
// and timer sizing.
package push_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2,
        LOCK   = 2'd3
    } push_state_t;

    localparam int unsigned CH_UP = 0;
    localparam int unsigned CH_DN = 1;

    // Bits needed to hold every value from 0 up to and including max_val.
    function automatic int unsigned timer_width(input int unsigned max_val);
        return (max_val == 0) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/push_channel.sv
// One button channel: polarity fix, 2-FF synchroniser, debouncer and the
// press / hold / auto-repeat / lockout FSM that emits single-cycle pulses.
module push_channel
    import push_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC   = 500000,
    parameter int unsigned REPEAT_DLY     = 25000000,
    parameter int unsigned REPEAT_PER     = 5000000,
    parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Btn,
    input  logic i_Inhibit,
    output logic o_Pulse,
    output logic o_Held
);

    localparam int unsigned DW = timer_width(DEBOUNCE_CYC);
    localparam int unsigned TW = timer_width((REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER);

    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYC - 1);
    // Expiry compares against the full delay, so repeats land DLY+1 / PER+1
    // cycles after the previous pulse (timer is cleared on the pulse cycle).
    localparam logic [TW-1:0] DLY_END = TW'(REPEAT_DLY);
    localparam logic [TW-1:0] PER_END = TW'(REPEAT_PER);

    logic          btn_pressed;
    logic [1:0]    sync_q;
    logic          held_q;
    logic [DW-1:0] db_cnt;
    push_state_t   state;
    logic [TW-1:0] timer;
    logic          pulse_q;

    assign btn_pressed = BTN_ACTIVE_LOW ? ~i_Btn : i_Btn;
    assign o_Held      = held_q;
    assign o_Pulse     = pulse_q;

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            sync_q <= '0;
            held_q <= 1'b0;
            db_cnt <= '0;
        end else begin
            sync_q <= {sync_q[0], btn_pressed};
            if (sync_q[1] == held_q) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                held_q <= ~held_q;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // Release is checked before inhibit and timer expiry so it always wins.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state   <= IDLE;
            timer   <= '0;
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (held_q) begin
                        timer <= '0;
                        if (i_Inhibit) begin
                            state <= LOCK;
                        end else begin
                            pulse_q <= 1'b1;
                            state   <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!held_q) begin
                        state <= IDLE;
                    end else if (i_Inhibit) begin
                        state <= LOCK;
                    end else if (timer == DLY_END) begin
                        pulse_q <= 1'b1;
                        timer   <= '0;
                        state   <= REPEAT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!held_q) begin
                        state <= IDLE;
                    end else if (i_Inhibit) begin
                        state <= LOCK;
                    end else if (timer == PER_END) begin
                        pulse_q <= 1'b1;
                        timer   <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                LOCK: begin
                    if (!held_q) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/push_pulse_gen.sv
// Two-channel up/down push-button front end; each channel's debounced level
// inhibits the other so the counter never sees both commands at once.
module push_pulse_gen
    import push_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC   = 500000,
    parameter int unsigned REPEAT_DLY     = 25000000,
    parameter int unsigned REPEAT_PER     = 5000000,
    parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [1:0] i_Btn,
    output logic [1:0] o_Push,
    output logic [1:0] o_Held
);

    push_channel #(
        .DEBOUNCE_CYC  (DEBOUNCE_CYC),
        .REPEAT_DLY    (REPEAT_DLY),
        .REPEAT_PER    (REPEAT_PER),
        .BTN_ACTIVE_LOW(BTN_ACTIVE_LOW)
    ) u_up (
        .i_Clk    (i_Clk),
        .i_Rst    (i_Rst),
        .i_Btn    (i_Btn[CH_UP]),
        .i_Inhibit(o_Held[CH_DN]),
        .o_Pulse  (o_Push[CH_UP]),
        .o_Held   (o_Held[CH_UP])
    );

    push_channel #(
        .DEBOUNCE_CYC  (DEBOUNCE_CYC),
        .REPEAT_DLY    (REPEAT_DLY),
        .REPEAT_PER    (REPEAT_PER),
        .BTN_ACTIVE_LOW(BTN_ACTIVE_LOW)
    ) u_dn (
        .i_Clk    (i_Clk),
        .i_Rst    (i_Rst),
        .i_Btn    (i_Btn[CH_DN]),
        .i_Inhibit(o_Held[CH_UP]),
        .o_Pulse  (o_Push[CH_DN]),
        .o_Held   (o_Held[CH_DN])
    );

endmodule

// File: tb/tb_push_pulse_gen.sv
// Directed bench for push_pulse_gen with short debounce/repeat timings;
// expected pulse cycles are hand-derived from the cycle the button changes.
module tb_push_pulse_gen;

    logic       i_Clk = 1'b0;
    logic       i_Rst;
    logic [1:0] i_Btn;
    logic [1:0] o_Push;
    logic [1:0] o_Held;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 i_Clk = ~i_Clk;

    push_pulse_gen #(
        .DEBOUNCE_CYC  (4),
        .REPEAT_DLY    (20),
        .REPEAT_PER    (8),
        .BTN_ACTIVE_LOW(1'b1)
    ) dut (
        .i_Clk (i_Clk),
        .i_Rst (i_Rst),
        .i_Btn (i_Btn),
        .o_Push(o_Push),
        .o_Held(o_Held)
    );

    task automatic check(input string tag, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_Clk);
        #1;
        cyc++;
    endtask

    task automatic step_check(input string tag, input logic [1:0] push_exp, input logic [1:0] held_exp);
        tick();
        check({tag, "_push"}, o_Push, push_exp);
        check({tag, "_held"}, o_Held, held_exp);
    endtask

    function automatic logic rng(input int k, input int lo, input int hi);
        return (k >= lo) && (k < hi);
    endfunction

    initial begin
        i_Rst = 1'b0;
        i_Btn = 2'b00;

        // reset with both raw inputs low (pressed level)
        for (int k = 1; k <= 3; k++) step_check("reset", 2'b00, 2'b00);
        i_Btn = 2'b11;
        tick();
        i_Rst = 1'b1;
        for (int k = 1; k <= 50; k++) step_check("idle", 2'b00, 2'b00);

        // single press, release after 10 cycles
        cyc = 0;
        i_Btn = 2'b10;
        for (int k = 1; k <= 30; k++) begin
            step_check("single", (k == 7) ? 2'b01 : 2'b00, {1'b0, rng(k, 6, 16)});
            if (k == 10) i_Btn = 2'b11;
        end

        // bounce on the down button, shorter than the debounce window
        cyc = 0;
        i_Btn = 2'b01;
        for (int k = 1; k <= 40; k++) begin
            step_check("bounce", 2'b00, 2'b00);
            if (k < 20 && (k % 2) == 0) i_Btn[1] = ~i_Btn[1];
        end

        // auto-repeat: first pulse, +21, then every 9
        cyc = 0;
        i_Btn = 2'b10;
        for (int k = 1; k <= 90; k++) begin
            step_check("repeat",
                       (k == 7 || k == 28 || k == 37 || k == 46 || k == 55) ? 2'b01 : 2'b00,
                       {1'b0, rng(k, 6, 62)});
            if (k == 56) i_Btn = 2'b11;
        end

        // simultaneous press: both locked, no pulses
        cyc = 0;
        i_Btn = 2'b00;
        for (int k = 1; k <= 60; k++) begin
            step_check("simul", 2'b00, rng(k, 6, 46) ? 2'b11 : 2'b00);
            if (k == 40) i_Btn = 2'b11;
        end

        // up, then down; release down; release and re-press up
        cyc = 0;
        i_Btn = 2'b10;
        for (int k = 1; k <= 135; k++) begin
            step_check("conflict",
                       (k == 7 || k == 117) ? 2'b01 : 2'b00,
                       {rng(k, 18, 66), rng(k, 6, 106) || rng(k, 116, 126)});
            case (k)
                12:  i_Btn = 2'b00;
                60:  i_Btn = 2'b10;
                100: i_Btn = 2'b11;
                110: i_Btn = 2'b10;
                120: i_Btn = 2'b11;
                default: ;
            endcase
        end

        // reset asserted right after a repeat pulse, button kept held
        cyc = 0;
        i_Btn = 2'b10;
        for (int k = 1; k <= 37; k++)
            step_check("rst_pre", (k == 7 || k == 28 || k == 37) ? 2'b01 : 2'b00, {1'b0, rng(k, 6, 200)});
        i_Rst = 1'b0;
        #1;
        check("rst_async_push", o_Push, 2'b00);
        check("rst_async_held", o_Held, 2'b00);
        for (int k = 1; k <= 3; k++) step_check("rst_hold", 2'b00, 2'b00);
        cyc = 0;
        i_Rst = 1'b1;
        for (int k = 1; k <= 55; k++) begin
            step_check("rst_post", (k == 7 || k == 28 || k == 37) ? 2'b01 : 2'b00, {1'b0, rng(k, 6, 45)});
            if (k == 39) i_Btn = 2'b11;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
